flappy_game_sequencer: RTL

//  Top-level sequencer for the bird datapath (controlBirdMovement) and score logic.
//  - Owns game state IDLE/PLAY/OVER.
//  - Divides Clock into game steps and drives the movement block's step enable.
//  - Converts raw button presses into one flap per step.
//  - Resets the bird on every new game.
//  - Ends the game on crash or on the movement block's gameOver.

---
 rtl/flappy_pkg.sv | 14 +
 rtl/flappy_game_sequencer_if.sv | 43 ++++
 rtl/btn_edge.sv | 35 +++
 rtl/flappy_game_sequencer.sv | 118 +++++++++++
 4 files changed

// File: rtl/flappy_pkg.sv
// flappy_pkg: shared types and constants for the flappy game sequencer.
//   game_state_e : IDLE / PLAY / OVER game state encoding
//   BIRD_HOME    : position the movement block returns the bird to on reset
package flappy_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } game_state_e;

    localparam logic [7:0] BIRD_HOME = 8'b00010000;

endpackage

// File: rtl/flappy_game_sequencer_if.sv
// flappy_game_sequencer_if: signals between the game sequencer and its
// surroundings (buttons, pipe logic, bird movement block).
//   master modport : the sequencer (consumes buttons/flags, drives controls)
//   slave modport  : the environment (drives buttons/flags, consumes controls)
// Signal semantics (there is no valid/ready pair on this bus):
//   start_btn, key_btn : raw asynchronous button levels
//   crash, bird_over   : level flags, sampled every cycle
//   pipe_pass          : one-cycle pulse per pipe cleared
//   step               : one-cycle enable to the movement block
//   flap               : key input to the movement block, meaningful with step
//   bird_reset         : one-cycle reset pulse to the movement block
//   playing, over      : decoded game state
//   score              : pipes passed this game (saturating)
//   dbg_state          : raw game state for observation
interface flappy_game_sequencer_if
    import flappy_pkg::*;
#(
    parameter int SCORE_W = 8
);
    logic               start_btn;
    logic               key_btn;
    logic               crash;
    logic               bird_over;
    logic               pipe_pass;
    logic               step;
    logic               flap;
    logic               bird_reset;
    logic               playing;
    logic               over;
    logic [SCORE_W-1:0] score;
    game_state_e        dbg_state;

    modport master (
        input  start_btn, key_btn, crash, bird_over, pipe_pass,
        output step, flap, bird_reset, playing, over, score, dbg_state
    );

    modport slave (
        output start_btn, key_btn, crash, bird_over, pipe_pass,
        input  step, flap, bird_reset, playing, over, score, dbg_state
    );

endinterface

// File: rtl/btn_edge.sv
// btn_edge: two-flop synchronizer followed by a registered rising-edge
// detector for a raw asynchronous button.
//   Clock : system clock
//   reset : synchronous active-high reset, clears all flops
//   btn   : raw button level
//   pulse : one-cycle pulse, three cycles after the raw rise; a held
//           button yields a single pulse
module btn_edge (
    input  logic Clock,
    input  logic reset,
    input  logic btn,
    output logic pulse
);

    logic sync1;
    logic sync2;
    logic sync3;

    always_ff @(posedge Clock) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
            pulse <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            sync3 <= sync2;
            // sync3 only holds history for the edge compare; sync2 is the
            // first metastability-safe sample.
            pulse <= sync2 & ~sync3;
        end
    end

endmodule

// File: rtl/flappy_game_sequencer.sv
// flappy_game_sequencer: top-level game sequencer for the bird movement
// block and score logic.
//   Clock : system clock, single domain
//   reset : synchronous active-high reset, overrides all other inputs
//   bus   : flappy_game_sequencer_if.master
//           inputs  start_btn, key_btn, crash, bird_over, pipe_pass
//           outputs step, flap, bird_reset, playing, over, score, dbg_state
// Game flow: IDLE --start--> PLAY --crash/bird_over--> OVER --start--> PLAY.
// In PLAY a tick counter divides Clock by TICK_DIV; step fires on the last
// tick. Flap requests are latched until the next step so a short press is
// never lost and repeated presses give a single flap.
module flappy_game_sequencer
    import flappy_pkg::*;
#(
    parameter int TICK_DIV = 16,
    parameter int SCORE_W  = 8
) (
    input  logic                      Clock,
    input  logic                      reset,
    flappy_game_sequencer_if.master   bus
);

    localparam int TW = $clog2(TICK_DIV);
    localparam logic [TW-1:0]      TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    game_state_e        state;
    logic [TW-1:0]      tick;
    logic               flap_pend;
    logic [SCORE_W-1:0] score_q;
    logic               bird_reset_q;

    logic start_edge;
    logic key_edge;

    btn_edge u_start_edge (
        .Clock (Clock),
        .reset (reset),
        .btn   (bus.start_btn),
        .pulse (start_edge)
    );

    btn_edge u_key_edge (
        .Clock (Clock),
        .reset (reset),
        .btn   (bus.key_btn),
        .pulse (key_edge)
    );

    logic in_play;
    logic end_req;
    logic step_w;

    assign in_play = (state == PLAY);

    // bird_reset_q is high exactly in the first PLAY cycle; the game-over
    // check is masked there so stale crash/bird_over from the previous game
    // cannot end the new one before the movement block has been reset.
    assign end_req = in_play & (bus.crash | bus.bird_over) & ~bird_reset_q;

    // A step must not reach the movement block in the cycle the game ends,
    // so the game-over condition gates it combinationally.
    assign step_w = in_play & (tick == TICK_LAST) & ~end_req;

    always_ff @(posedge Clock) begin
        if (reset) begin
            state        <= IDLE;
            tick         <= '0;
            flap_pend    <= 1'b0;
            score_q      <= '0;
            bird_reset_q <= 1'b0;
        end else begin
            bird_reset_q <= 1'b0;
            case (state)
                IDLE, OVER: begin
                    tick <= '0;
                    if (start_edge) begin
                        state        <= PLAY;
                        bird_reset_q <= 1'b1;
                        score_q      <= '0;
                        flap_pend    <= 1'b0;
                    end
                end
                PLAY: begin
                    if (bus.pipe_pass && (score_q != SCORE_MAX)) begin
                        score_q <= score_q + 1'b1;
                    end
                    if (end_req) begin
                        state     <= OVER;
                        tick      <= '0;
                        flap_pend <= 1'b0;
                    end else begin
                        tick <= (tick == TICK_LAST) ? '0 : tick + TW'(1);
                        // A key edge coincident with the step is consumed
                        // by that step through the flap output.
                        if (step_w) begin
                            flap_pend <= 1'b0;
                        end else if (key_edge) begin
                            flap_pend <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.step       = step_w;
    assign bus.flap       = in_play & (flap_pend | key_edge);
    assign bus.bird_reset = bird_reset_q;
    assign bus.playing    = in_play;
    assign bus.over       = (state == OVER);
    assign bus.score      = score_q;
    assign bus.dbg_state  = state;

endmodule
